// File: rtl/lfu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfu_pkg
// Brief    : Shared scan-FSM state encodings and the per-counter next-count rule.
// Revision : 1.0 - initial release
// ============================================================================
package lfu_pkg;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_SCAN = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  // Fill wins over everything; aging halves the set and re-seeds the hit way.
  function automatic logic [15:0] lfu_next(input logic [15:0] cur,
                                           input logic [15:0] cnt_max,
                                           input logic        fill,
                                           input logic        hit,
                                           input logic        age);
    logic [15:0] v;
    v = cur;
    if (fill)
      v = 16'd1;
    else if (age)
      v = hit ? ((cnt_max >> 1) + 16'd1) : (cur >> 1);
    else if (hit && (cur != cnt_max))
      v = cur + 16'd1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfu_way_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : lfu_way_tracker_if
// Brief    : Hit/fill update, victim request/response and debug read bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface lfu_way_tracker_if #(
  parameter int SET_BITS = 6,
  parameter int WAYS     = 4,
  parameter int CNT_W    = 4
);
  localparam int WAY_W = $clog2(WAYS);

  logic                hit_valid;
  logic [SET_BITS-1:0] hit_set;
  logic [WAY_W-1:0]    hit_way;
  logic                fill_valid;
  logic [SET_BITS-1:0] fill_set;
  logic [WAY_W-1:0]    fill_way;
  logic                victim_req;
  logic [SET_BITS-1:0] victim_set;
  logic                victim_ready;
  logic                victim_valid;
  logic [WAY_W-1:0]    victim_way;
  logic [CNT_W-1:0]    victim_count;
  logic                count_read;
  logic [SET_BITS-1:0] count_set;
  logic [WAY_W-1:0]    count_way;
  logic [CNT_W-1:0]    count_out;

  modport slave (
    input  hit_valid, hit_set, hit_way, fill_valid, fill_set, fill_way,
    input  victim_req, victim_set, count_read, count_set, count_way,
    output victim_ready, victim_valid, victim_way, victim_count, count_out
  );

  modport master (
    output hit_valid, hit_set, hit_way, fill_valid, fill_set, fill_way,
    output victim_req, victim_set, count_read, count_set, count_way,
    input  victim_ready, victim_valid, victim_way, victim_count, count_out
  );
endinterface
`default_nettype wire

// File: rtl/lfu_victim_scan.sv
`default_nettype none
// ============================================================================
// Module   : lfu_victim_scan
// Brief    : IDLE/SCAN/DONE FSM walking one way per cycle to find the LFU way.
// Revision : 1.0 - initial release
// ============================================================================
module lfu_victim_scan
  import lfu_pkg::*;
#(
  parameter int SET_BITS = 6,
  parameter int WAYS     = 4,
  parameter int CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      gen_reset,
  input  logic                      req,
  input  logic [SET_BITS-1:0]       req_set,
  input  logic [CNT_W-1:0]          set_cnts [WAYS],
  output logic [SET_BITS-1:0]       scan_set,
  output logic                      ready,
  output logic                      valid,
  output logic [$clog2(WAYS)-1:0]   way,
  output logic [CNT_W-1:0]          count
);
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [WAY_W-1:0] c_LAST = WAY_W'(WAYS - 1);

  logic [1:0]          r_state;
  logic [SET_BITS-1:0] r_set;
  logic [WAY_W-1:0]    r_idx;
  logic [WAY_W-1:0]    r_best_way;
  logic [CNT_W-1:0]    r_best_cnt;
  logic                r_valid;
  logic [WAY_W-1:0]    r_way;
  logic [CNT_W-1:0]    r_count;

  logic [CNT_W-1:0]    w_cur;
  logic                w_better;

  assign w_cur    = set_cnts[r_idx];
  // Way 0 seeds the running best; strict less-than keeps the lowest index on ties.
  assign w_better = (r_idx == '0) || (w_cur < r_best_cnt);

  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      r_state    <= c_ST_IDLE;
      r_set      <= '0;
      r_idx      <= '0;
      r_best_way <= '0;
      r_best_cnt <= '0;
      r_valid    <= 1'b0;
      r_way      <= '0;
      r_count    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (req) begin
            r_set      <= req_set;
            r_idx      <= '0;
            r_best_way <= '0;
            r_best_cnt <= '0;
            r_state    <= c_ST_SCAN;
          end
        end
        c_ST_SCAN: begin
          if (w_better) begin
            r_best_cnt <= w_cur;
            r_best_way <= r_idx;
          end
          if (r_idx == c_LAST)
            r_state <= c_ST_DONE;
          else
            r_idx <= r_idx + WAY_W'(1);
        end
        c_ST_DONE: begin
          r_valid <= 1'b1;
          r_way   <= r_best_way;
          r_count <= r_best_cnt;
          r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign scan_set = r_set;
  assign ready    = (r_state == c_ST_IDLE);
  assign valid    = r_valid;
  assign way      = r_way;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/lfu_way_tracker.sv
`default_nettype none
// ============================================================================
// Module   : lfu_way_tracker
// Brief    : Per-way saturating use counters for every set plus an LFU victim
//            scanner. Define LFU_AGING_EN to halve a set when a hit saturates.
// Revision : 1.0 - initial release
// ============================================================================
module lfu_way_tracker
  import lfu_pkg::*;
#(
  parameter int SET_BITS = 6,
  parameter int WAYS     = 4,
  parameter int CNT_W    = 4
) (
  input  logic                    clk,
  input  logic                    gen_reset,
  lfu_way_tracker_if.slave        bus
);
  localparam int SETS  = 2 ** SET_BITS;
  localparam int WAY_W = $clog2(WAYS);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [CNT_W-1:0]    r_cnt       [SETS][WAYS];
  logic [CNT_W-1:0]    w_cnt_nxt   [SETS][WAYS];
  logic [CNT_W-1:0]    w_scan_cnts [WAYS];
  logic [SET_BITS-1:0] w_scan_set;
  logic [CNT_W-1:0]    r_count_out;
  logic                w_age_hit;

`ifdef LFU_AGING_EN
  assign w_age_hit = bus.hit_valid && (r_cnt[bus.hit_set][bus.hit_way] == c_CNT_MAX);
`else
  assign w_age_hit = 1'b0;
`endif

  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        w_cnt_nxt[s][w] = CNT_W'(lfu_next(
          16'(r_cnt[s][w]), 16'(c_CNT_MAX),
          bus.fill_valid && (bus.fill_set == SET_BITS'(s)) && (bus.fill_way == WAY_W'(w)),
          bus.hit_valid  && (bus.hit_set  == SET_BITS'(s)) && (bus.hit_way  == WAY_W'(w)),
          w_age_hit      && (bus.hit_set  == SET_BITS'(s))));
      end
    end
  end

  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_cnt[s][w] <= '0;
      r_count_out <= '0;
    end else begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_cnt[s][w] <= w_cnt_nxt[s][w];
      if (bus.count_read)
        r_count_out <= r_cnt[bus.count_set][bus.count_way];
    end
  end

  // The scanner sees the registered counters of its latched set.
  always_comb begin
    for (int w = 0; w < WAYS; w++)
      w_scan_cnts[w] = r_cnt[w_scan_set][w];
  end

  lfu_victim_scan #(
    .SET_BITS (SET_BITS),
    .WAYS     (WAYS),
    .CNT_W    (CNT_W)
  ) u_scan (
    .clk       (clk),
    .gen_reset (gen_reset),
    .req       (bus.victim_req),
    .req_set   (bus.victim_set),
    .set_cnts  (w_scan_cnts),
    .scan_set  (w_scan_set),
    .ready     (bus.victim_ready),
    .valid     (bus.victim_valid),
    .way       (bus.victim_way),
    .count     (bus.victim_count)
  );

  assign bus.count_out = r_count_out;

endmodule
`default_nettype wire

// File: tb/tb_lfu_way_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfu_way_tracker
// Brief    : Directed self-checking bench for lfu_way_tracker (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfu_way_tracker;

  logic clk = 1'b0;
  logic gen_reset;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  lfu_way_tracker_if #(.SET_BITS(6), .WAYS(4), .CNT_W(4)) bus ();

  lfu_way_tracker #(.SET_BITS(6), .WAYS(4), .CNT_W(4)) dut (
    .clk       (clk),
    .gen_reset (gen_reset),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input int s, input int w);
    bus.fill_valid = 1'b1; bus.fill_set = 6'(s); bus.fill_way = 2'(w);
    tick();
    bus.fill_valid = 1'b0;
  endtask

  task automatic do_hit(input int s, input int w);
    bus.hit_valid = 1'b1; bus.hit_set = 6'(s); bus.hit_way = 2'(w);
    tick();
    bus.hit_valid = 1'b0;
  endtask

  task automatic set_count(input int s, input int w, input int n);
    do_fill(s, w);
    for (int i = 1; i < n; i++) do_hit(s, w);
  endtask

  task automatic rd(input int s, input int w, output logic [31:0] val);
    bus.count_read = 1'b1; bus.count_set = 6'(s); bus.count_way = 2'(w);
    tick();
    bus.count_read = 1'b0;
    val = 32'(bus.count_out);
  endtask

  task automatic scan(input string tag, input int s, input int ew, input int ec);
    int lat;
    bit seen;
    lat = 0; seen = 1'b0;
    bus.victim_req = 1'b1; bus.victim_set = 6'(s);
    tick();
    bus.victim_req = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      tick();
      if (bus.victim_valid) begin seen = 1'b1; lat = i; end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_way"}, 32'(bus.victim_way), 32'(ew));
    chk({tag, "_cnt"}, 32'(bus.victim_count), 32'(ec));
  endtask

  initial begin
    bit seen_v;
    gen_reset = 1'b1;
    bus.hit_valid = 0; bus.hit_set = 0; bus.hit_way = 0;
    bus.fill_valid = 0; bus.fill_set = 0; bus.fill_way = 0;
    bus.victim_req = 0; bus.victim_set = 0;
    bus.count_read = 0; bus.count_set = 0; bus.count_way = 0;
    tick(); tick();
    chk("rst_ready", 32'(bus.victim_ready), 32'd1);
    chk("rst_valid", 32'(bus.victim_valid), 32'd0);
    chk("rst_way",   32'(bus.victim_way),   32'd0);
    chk("rst_vcnt",  32'(bus.victim_count), 32'd0);
    chk("rst_cout",  32'(bus.count_out),    32'd0);
    gen_reset = 1'b0;
    tick();

    // 1: debug read after reset
    rd(0, 2, v); chk("t1_cnt_s0w2", v, 32'd0);
    chk("t1_ready", 32'(bus.victim_ready), 32'd1);
    chk("t1_valid", 32'(bus.victim_valid), 32'd0);
    tick();
    chk("t1_hold", 32'(bus.count_out), 32'd0);

    // 2: fill then three hits
    set_count(3, 1, 4);
    rd(3, 1, v); chk("t2_s3w1", v, 32'd4);
    rd(3, 0, v); chk("t2_s3w0", v, 32'd0);

    // 3: saturation (or aging) after 20 hits
    set_count(7, 2, 21);
    rd(7, 2, v);
`ifdef LFU_AGING_EN
    chk("t3_s7w2", v, 32'd13);
`else
    chk("t3_s7w2", v, 32'd15);
`endif

    // 4: victim scan on {3,1,1,7}, extra request during the scan ignored
    set_count(5, 0, 3); set_count(5, 1, 1); set_count(5, 2, 1); set_count(5, 3, 7);
    bus.victim_req = 1'b1; bus.victim_set = 6'd5;
    tick();
    bus.victim_req = 1'b0;
    chk("t4_busy0", 32'(bus.victim_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) begin bus.victim_req = 1'b1; bus.victim_set = 6'd0; end
      tick();
      bus.victim_req = 1'b0;
      chk($sformatf("t4_early_valid%0d", i), 32'(bus.victim_valid), 32'd0);
      chk($sformatf("t4_busy%0d", i), 32'(bus.victim_ready), 32'd0);
    end
    tick();
    chk("t4_valid", 32'(bus.victim_valid), 32'd1);
    chk("t4_way",   32'(bus.victim_way),   32'd1);
    chk("t4_cnt",   32'(bus.victim_count), 32'd1);
    chk("t4_ready", 32'(bus.victim_ready), 32'd1);
    tick();
    chk("t4_pulse", 32'(bus.victim_valid), 32'd0);
    chk("t4_hold",  32'(bus.victim_way),   32'd1);

    // 5: hit/fill collision and parallel updates
    set_count(4, 0, 6);
    rd(4, 0, v); chk("t5_pre", v, 32'd6);
    bus.hit_valid = 1'b1;  bus.hit_set = 6'd4;  bus.hit_way = 2'd0;
    bus.fill_valid = 1'b1; bus.fill_set = 6'd4; bus.fill_way = 2'd0;
    tick();
    bus.hit_valid = 1'b0; bus.fill_valid = 1'b0;
    rd(4, 0, v); chk("t5_same", v, 32'd1);
    set_count(4, 2, 3); set_count(4, 1, 1);
    bus.hit_valid = 1'b1;  bus.hit_set = 6'd4;  bus.hit_way = 2'd1;
    bus.fill_valid = 1'b1; bus.fill_set = 6'd4; bus.fill_way = 2'd2;
    tick();
    bus.hit_valid = 1'b0; bus.fill_valid = 1'b0;
    rd(4, 1, v); chk("t5_hit_w1", v, 32'd2);
    rd(4, 2, v); chk("t5_fill_w2", v, 32'd1);

    // Scans: set 4 is {1,2,1,0}; set 3 is {0,4,0,0} (tie -> lowest way)
    scan("sc_s4", 4, 3, 0);
    scan("sc_s3", 3, 0, 0);

    // 6: saturating hit on {15,8,3,0}
    set_count(2, 0, 15); set_count(2, 1, 8); set_count(2, 2, 3);
    do_hit(2, 0);
    rd(2, 0, v);
`ifdef LFU_AGING_EN
    chk("t6_w0", v, 32'd8);
    rd(2, 1, v); chk("t6_w1", v, 32'd4);
    rd(2, 2, v); chk("t6_w2", v, 32'd1);
`else
    chk("t6_w0", v, 32'd15);
    rd(2, 1, v); chk("t6_w1", v, 32'd8);
    rd(2, 2, v); chk("t6_w2", v, 32'd3);
`endif
    rd(2, 3, v); chk("t6_w3", v, 32'd0);

    // Reset two cycles into a scan
    bus.victim_req = 1'b1; bus.victim_set = 6'd5;
    tick();
    bus.victim_req = 1'b0;
    tick(); tick();
    gen_reset = 1'b1;
    #2;
    chk("rs_ready", 32'(bus.victim_ready), 32'd1);
    chk("rs_valid", 32'(bus.victim_valid), 32'd0);
    #2;
    gen_reset = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.victim_valid) seen_v = 1'b1;
    end
    chk("rs_no_pulse", 32'(seen_v), 32'd0);
    chk("rs_ready2", 32'(bus.victim_ready), 32'd1);
    rd(5, 3, v); chk("rs_s5w3", v, 32'd0);
    rd(3, 1, v); chk("rs_s3w1", v, 32'd0);
    rd(7, 2, v); chk("rs_s7w2", v, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
